// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped prescaled timer with compare, overflow and interrupt
// Four word registers at BASE: CTRL, COUNT, CMP, STATUS (sticky W1C flags).
module mmio_timer #(
   parameter logic [31:0] BASE = 32'h0000_0200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   output logic [31:0] ReadData,
   output logic        Sel,
   output logic        Irq
);

   logic        en;
   logic        autorld;
   logic        irqen;
   logic [7:0]  presc;
   logic [7:0]  prescaler;
   logic [31:0] count;
   logic [31:0] cmp;
   logic        match;
   logic        ovf;
   logic        irq;

   logic        wr;
   logic        wr_ctrl;
   logic        wr_count;
   logic        wr_cmp;
   logic        wr_status;
   logic        tick;
   logic        hit;
   logic        wrap;
   logic        unused_bits;

   assign Sel         = (DataAdr[31:4] == BASE[31:4]);
   assign unused_bits = ^DataAdr[1:0];

   assign wr        = MemWrite & Sel;
   assign wr_ctrl   = wr & (DataAdr[3:2] == 2'd0);
   assign wr_count  = wr & (DataAdr[3:2] == 2'd1);
   assign wr_cmp    = wr & (DataAdr[3:2] == 2'd2);
   assign wr_status = wr & (DataAdr[3:2] == 2'd3);

   // Match and wrap are judged on the pre-edge COUNT and CMP, so same-cycle writes cannot mask them.
   assign tick = en & (prescaler == presc);
   assign hit  = tick & (count == cmp);
   assign wrap = tick & ~hit & (count == 32'hFFFF_FFFF);

   always_ff @(posedge clk) begin
      if (reset) begin
         en        <= 1'b0;
         autorld   <= 1'b0;
         irqen     <= 1'b0;
         presc     <= 8'd0;
         prescaler <= 8'd0;
         count     <= 32'd0;
         cmp       <= 32'hFFFF_FFFF;
         match     <= 1'b0;
         ovf       <= 1'b0;
         irq       <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            en        <= WriteData[0];
            autorld   <= WriteData[1];
            irqen     <= WriteData[2];
            presc     <= WriteData[15:8];
            prescaler <= 8'd0;
         end else if (tick) begin
            prescaler <= 8'd0;
         end else if (en) begin
            prescaler <= prescaler + 8'd1;
         end

         if (wr_count) begin
            count <= WriteData;
         end else if (tick) begin
            count <= (hit && autorld) ? 32'd0 : count + 32'd1;
         end

         if (wr_cmp) begin
            cmp <= WriteData;
         end

         // Hardware set wins over a simultaneous software clear.
         match <= hit  | (match & ~(wr_status & WriteData[0]));
         ovf   <= wrap | (ovf   & ~(wr_status & WriteData[1]));
         irq   <= (match | ovf) & irqen;
      end
   end

   assign Irq = irq;

   always_comb begin
      ReadData = 32'd0;
      if (Sel) begin
         case (DataAdr[3:2])
            2'd0:    ReadData = {16'd0, presc, 5'd0, irqen, autorld, en};
            2'd1:    ReadData = count;
            2'd2:    ReadData = cmp;
            default: ReadData = {30'd0, ovf, match};
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - directed scoreboard bench for mmio_timer
// Inputs change 1 ns after each rising edge; outputs are sampled mid-cycle.
module tb_mmio_timer;

   localparam logic [31:0] BASE    = 32'h0000_0200;
   localparam logic [31:0] A_CTRL  = BASE + 32'h0;
   localparam logic [31:0] A_COUNT = BASE + 32'h4;
   localparam logic [31:0] A_CMP   = BASE + 32'h8;
   localparam logic [31:0] A_STAT  = BASE + 32'hC;

   logic        clk;
   logic        reset;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic [31:0] ReadData;
   logic        Sel;
   logic        Irq;

   int compared   = 0;
   int mismatched = 0;
   logic [31:0] exp_q[$];

   mmio_timer #(.BASE(BASE)) dut (
      .clk(clk),
      .reset(reset),
      .DataAdr(DataAdr),
      .WriteData(WriteData),
      .MemWrite(MemWrite),
      .ReadData(ReadData),
      .Sel(Sel),
      .Irq(Irq)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic expect_val(input logic [31:0] e);
      exp_q.push_back(e);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      e = exp_q.pop_front();
      compared++;
      assert (obs === e) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [31:0] a, input logic [31:0] d);
      DataAdr   = a;
      WriteData = d;
      MemWrite  = 1'b1;
      cycles(1);
      MemWrite  = 1'b0;
   endtask

   task automatic read(input string tag, input logic [31:0] a, input logic [31:0] e);
      DataAdr  = a;
      MemWrite = 1'b0;
      expect_val(e);
      #1;
      check(tag, ReadData);
   endtask

   task automatic check_irq(input string tag, input logic e);
      expect_val({31'd0, e});
      check(tag, {31'd0, Irq});
   endtask

   initial begin
      reset     = 1'b1;
      DataAdr   = 32'd0;
      WriteData = 32'd0;
      MemWrite  = 1'b0;

      // reset held two cycles; register values visible while still in reset
      cycles(1);
      read("rst_cmp_during", A_CMP, 32'hFFFF_FFFF);
      cycles(1);
      reset = 1'b0;
      read("rst_ctrl",   A_CTRL,  32'd0);
      read("rst_count",  A_COUNT, 32'd0);
      read("rst_cmp",    A_CMP,   32'hFFFF_FFFF);
      read("rst_status", A_STAT,  32'd0);
      check_irq("rst_irq", 1'b0);

      // prescale 2 -> tick every 3 cycles, autoreload on match at 3
      write(A_CMP, 32'd3);
      write(A_CTRL, 32'h0000_0207);
      read("ctrl_rb", A_CTRL, 32'h0000_0207);
      read("pre_c0", A_COUNT, 32'd0);
      cycles(2);
      read("pre_c0_hold", A_COUNT, 32'd0);
      cycles(1);
      read("pre_c1", A_COUNT, 32'd1);
      cycles(3);
      read("pre_c2", A_COUNT, 32'd2);
      cycles(3);
      read("pre_c3", A_COUNT, 32'd3);
      read("pre_st0", A_STAT, 32'd0);
      cycles(3);
      read("pre_c_reload", A_COUNT, 32'd0);
      read("pre_match", A_STAT, 32'd1);
      check_irq("pre_irq_lag", 1'b0);
      cycles(1);
      check_irq("pre_irq", 1'b1);

      // W1C racing a match tick loses; W1C on a quiet cycle clears
      cycles(10);
      read("race_c3", A_COUNT, 32'd3);
      write(A_STAT, 32'd1);
      read("race_match_kept", A_STAT, 32'd1);
      read("race_c_reload", A_COUNT, 32'd0);
      write(A_STAT, 32'd1);
      read("w1c_clear", A_STAT, 32'd0);
      cycles(1);
      check_irq("w1c_irq", 1'b0);

      // 32-bit wrap sets OVF, no interrupt without IRQEN
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
      write(A_COUNT, 32'hFFFF_FFFF);
      write(A_CMP, 32'd5);
      write(A_CTRL, 32'd1);
      read("wrap_pre", A_COUNT, 32'hFFFF_FFFF);
      cycles(1);
      read("wrap_count", A_COUNT, 32'd0);
      read("wrap_ovf", A_STAT, 32'd2);
      cycles(1);
      check_irq("wrap_irq", 1'b0);
      read("wrap_c1", A_COUNT, 32'd1);

      // software COUNT write beats the tick increment
      write(A_COUNT, 32'h10);
      read("wpri_count", A_COUNT, 32'h10);
      cycles(1);
      read("wpri_next", A_COUNT, 32'h11);
      read("wpri_status", A_STAT, 32'd2);

      // disabling: the CTRL-write cycle still ticks, then everything holds
      write(A_CTRL, 32'd0);
      cycles(3);
      read("hold_count", A_COUNT, 32'h12);
      read("hold_status", A_STAT, 32'd2);
      read("byte_off", BASE + 32'h5, 32'h12);

      // out-of-window stores are ignored
      DataAdr = BASE + 32'h10;
      #1;
      expect_val(32'd0); check("dec_sel_hi", {31'd0, Sel});
      expect_val(32'd0); check("dec_rd_hi", ReadData);
      write(BASE + 32'h10, 32'd7);
      DataAdr = 32'd100;
      #1;
      expect_val(32'd0); check("dec_sel_100", {31'd0, Sel});
      expect_val(32'd0); check("dec_rd_100", ReadData);
      write(32'd100, 32'd7);
      read("dec_ctrl",  A_CTRL,  32'd0);
      read("dec_count", A_COUNT, 32'h12);
      read("dec_cmp",   A_CMP,   32'd5);
      read("dec_stat",  A_STAT,  32'd2);

      // reset mid-count beats a simultaneous COUNT write
      write(A_CTRL, 32'd1);
      cycles(2);
      reset     = 1'b1;
      DataAdr   = A_COUNT;
      WriteData = 32'h55;
      MemWrite  = 1'b1;
      cycles(1);
      MemWrite  = 1'b0;
      read("rpri_count", A_COUNT, 32'd0);
      read("rpri_ctrl",  A_CTRL,  32'd0);
      read("rpri_cmp",   A_CMP,   32'hFFFF_FFFF);
      read("rpri_stat",  A_STAT,  32'd0);
      reset = 1'b0;
      cycles(2);
      read("rpri_idle", A_COUNT, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
